// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions for the ID-stage hazard control unit.
package hazard_control_unit_pkg;

  localparam int unsigned REG_ADDR_W_DFLT = 5;

  // addi x0, x0, 0 -- what the IF/ID and ID/EX flush muxes load
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_e;

endpackage

// File: rtl/hazard_stall_counter.sv
// Loadable down-counter with a nonzero flag; stops at zero instead of wrapping.
module hazard_stall_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         nonzero
);

  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (load)
      count <= loadVal;
    else if (dec && nonzero)
      count <= count - W'(1);
  end

  assign nonzero = |count;

endmodule

// File: rtl/hazard_control_unit.sv
// ID-stage hazard control: multi-cycle load-use stalls, MUL/DIV busy sequencing
// and taken-branch flush, driving all PC / IF/ID / ID/EX hold and flush controls.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DFLT,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned MD_LAT     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  if_id_use_rs1,
  input  logic                  if_id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_mem_read,
  input  logic                  id_ex_md_start,
  input  logic                  branch_taken,
  output logic                  pc_hold,
  output logic                  id_ex_bubble,
  output logic                  ex_hold,
  output logic                  if_id_flush,
  output logic                  md_busy
);

  localparam int unsigned MW = $clog2(MD_LAT);

  md_state_e      state, stateNext;
  logic [3:0]     lcnt;
  logic           lNz;
  logic [MW-1:0]  mcnt;
  logic           mNz;
  logic           hit, mdActive, mdLast, loadStall;
  logic           lLoad, lDec, lClear, mLoad, mDec;

  hazard_stall_counter #(.W(4)) uLoadCnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (lClear),
    .load    (lLoad),
    .loadVal (4'(LOAD_LAT - 1)),
    .dec     (lDec),
    .count   (lcnt),
    .nonzero (lNz)
  );

  hazard_stall_counter #(.W(MW)) uMdCnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (1'b0),
    .load    (mLoad),
    .loadVal (MW'(MD_LAT - 1)),
    .dec     (mDec),
    .count   (mcnt),
    .nonzero (mNz)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= MD_IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    mdActive     = 1'b0;
    mdLast       = 1'b0;
    mLoad        = 1'b0;
    mDec         = 1'b0;
    hit = id_ex_mem_read && (id_ex_rd != '0) &&
          ((if_id_use_rs1 && (if_id_rs1 == id_ex_rd)) ||
           (if_id_use_rs2 && (if_id_rs2 == id_ex_rd)));

    unique case (state)
      MD_IDLE: begin
        if (id_ex_md_start) begin
          mdActive  = 1'b1;
          mLoad     = 1'b1;
          stateNext = MD_BUSY;
        end
      end
      MD_BUSY: begin
        mdActive = 1'b1;
        mDec     = 1'b1;
        mdLast   = !mNz || (mcnt == MW'(1));
        if (mdLast)
          stateNext = MD_IDLE;
      end
      default: stateNext = MD_IDLE;
    endcase

    // MD occupancy freezes the load counter; a pending hit is re-examined once IDLE
    loadStall = !mdActive && !branch_taken && (lNz || hit);
    lLoad     = loadStall && (lcnt == '0);
    lDec      = loadStall && lNz;
    lClear    = !mdActive && branch_taken;

    pc_hold      = !rst && (mdActive || loadStall);
    id_ex_bubble = !rst && !mdActive && (branch_taken || loadStall);
    ex_hold      = !rst && mdActive && !mdLast;
    if_id_flush  = !rst && !mdActive && branch_taken;
    md_busy      = !rst && mdActive;
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two parameterisations driven in lockstep,
// checked against a table of hand-derived vectors and a cycle-count model.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, use1, use2, memRead, mdStart, branch;
  logic [4:0] rs1, rs2, rd;
  logic       aPc, aBub, aEx, aFl, aBusy;
  logic       bPc, bBub, bEx, bFl, bBusy;
  logic [4:0] outsA, outsB;

  assign outsA = {aPc, aBub, aEx, aFl, aBusy};
  assign outsB = {bPc, bBub, bEx, bFl, bBusy};

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_LAT(3), .MD_LAT(4)) dutA (
    .clk(clk), .rst(rst), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_use_rs1(use1), .if_id_use_rs2(use2), .id_ex_rd(rd),
    .id_ex_mem_read(memRead), .id_ex_md_start(mdStart), .branch_taken(branch),
    .pc_hold(aPc), .id_ex_bubble(aBub), .ex_hold(aEx), .if_id_flush(aFl), .md_busy(aBusy)
  );

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_LAT(1), .MD_LAT(32)) dutB (
    .clk(clk), .rst(rst), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_use_rs1(use1), .if_id_use_rs2(use2), .id_ex_rd(rd),
    .id_ex_mem_read(memRead), .id_ex_md_start(mdStart), .branch_taken(branch),
    .pc_hold(bPc), .id_ex_bubble(bBub), .ex_hold(bEx), .if_id_flush(bFl), .md_busy(bBusy)
  );

  int tests = 0;
  int fails = 0;
  // model state: remaining stall cycles / remaining MD occupancy cycles
  int aLd = 0, aMd = 0, bLd = 0, bMd = 0;
  int bBusyCnt = 0, bExCnt = 0;

  typedef struct {
    logic       r;
    logic [4:0] a, b, d;
    logic       u1, u2, mr, ms, br;
    logic [4:0] e;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t v(logic r, logic [4:0] a, logic [4:0] b, logic [4:0] d,
                             logic u1, logic u2, logic mr, logic ms, logic br, logic [4:0] e);
    vec_t x;
    x.r = r; x.a = a; x.b = b; x.d = d;
    x.u1 = u1; x.u2 = u2; x.mr = mr; x.ms = ms; x.br = br; x.e = e;
    return x;
  endfunction

  function automatic logic hitNow();
    return memRead && (rd != 5'd0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
  endfunction

  // outputs packed as {pc_hold, id_ex_bubble, ex_hold, if_id_flush, md_busy}
  task automatic modelStep(input int loadLat, input int mdLat,
                           inout int ldRem, inout int mdRem, output logic [4:0] e);
    int mdNow;
    e = 5'b00000;
    if (rst) begin
      ldRem = 0;
      mdRem = 0;
      return;
    end
    mdNow = (mdRem > 0) ? mdRem : (mdStart ? mdLat : 0);
    if (mdNow > 0) begin
      e = {1'b1, 1'b0, (mdNow > 1), 1'b0, 1'b1};
      mdRem = mdNow - 1;
    end else if (branch) begin
      e = 5'b01010;
      ldRem = 0;
    end else if (ldRem > 0 || hitNow()) begin
      e = 5'b11000;
      ldRem = (ldRem > 0) ? ldRem - 1 : loadLat - 1;
    end
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic setIn(input vec_t x);
    rst = x.r; rs1 = x.a; rs2 = x.b; rd = x.d;
    use1 = x.u1; use2 = x.u2; memRead = x.mr; mdStart = x.ms; branch = x.br;
  endtask

  // inputs already applied just after a negedge; sample, check, advance to next negedge
  task automatic cycle(input string tag, input bit useA, input logic [4:0] expA,
                       input bit useB, input logic [4:0] expB);
    logic [4:0] ea, eb;
    #2;
    modelStep(3, 4, aLd, aMd, ea);
    modelStep(1, 32, bLd, bMd, eb);
    if (useA) check({tag, " A-table"}, outsA, expA);
    if (useB) check({tag, " B-table"}, outsB, expB);
    check({tag, " A-model"}, outsA, ea);
    check({tag, " B-model"}, outsB, eb);
    if (bBusy) bBusyCnt++;
    if (bEx) bExCnt++;
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = v(1, 5, 0, 5, 1, 0, 1, 1, 0, 5'b00000);
    tbl[1]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    tbl[2]  = v(0, 5, 0, 5, 1, 0, 1, 0, 0, 5'b11000);
    tbl[3]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
    tbl[4]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
    tbl[5]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    tbl[6]  = v(0, 0, 0, 0, 1, 0, 1, 0, 0, 5'b00000);
    tbl[7]  = v(0, 5, 0, 5, 0, 0, 1, 0, 0, 5'b00000);
    tbl[8]  = v(0, 7, 7, 7, 0, 1, 1, 0, 0, 5'b11000);
    tbl[9]  = v(0, 7, 7, 7, 0, 1, 1, 0, 1, 5'b01010);
    tbl[10] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    tbl[11] = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b10101);
    tbl[12] = v(0, 5, 0, 5, 1, 0, 1, 1, 0, 5'b10101);
    tbl[13] = v(0, 5, 0, 5, 1, 0, 1, 0, 0, 5'b10101);
    tbl[14] = v(0, 5, 0, 5, 1, 0, 1, 0, 0, 5'b10001);
    tbl[15] = v(0, 5, 0, 5, 1, 0, 1, 0, 0, 5'b11000);
    tbl[16] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
    tbl[17] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
    tbl[18] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    tbl[19] = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b10101);
    tbl[20] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    tbl[21] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    tbl[22] = v(0, 5, 0, 5, 1, 0, 1, 0, 0, 5'b11000);
    tbl[23] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    tbl[24] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);

    setIn(tbl[1]);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      setIn(tbl[i]);
      cycle($sformatf("row%0d", i), 1'b1, tbl[i].e, 1'b0, 5'b00000);
    end

    // LOAD_LAT=1: single bubble only
    setIn(v(0, 5, 0, 5, 1, 0, 1, 0, 0, 5'b00000));
    cycle("ll1-hit", 1'b0, 5'b00000, 1'b1, 5'b11000);
    setIn(tbl[1]);
    cycle("ll1-after", 1'b0, 5'b00000, 1'b1, 5'b00000);
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 5'b00000, 1'b0, 5'b00000);

    // MD_LAT=32: full occupancy count, then back to idle
    bBusyCnt = 0;
    bExCnt   = 0;
    setIn(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000));
    cycle("md32-start", 1'b0, 5'b00000, 1'b1, 5'b10101);
    setIn(tbl[1]);
    for (int i = 0; i < 39; i++) cycle("md32-run", 1'b0, 5'b00000, 1'b0, 5'b00000);
    tests++;
    if (bBusyCnt != 32 || bExCnt != 31) begin
      fails++;
      $display("FAIL md32-count: busy=%0d ex_hold=%0d expected busy=32 ex_hold=31", bBusyCnt, bExCnt);
    end

    // MD_LAT=32 aborted by reset in its second cycle
    setIn(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000));
    cycle("md32-abort0", 1'b0, 5'b00000, 1'b1, 5'b10101);
    setIn(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
    cycle("md32-abort1", 1'b0, 5'b00000, 1'b1, 5'b00000);
    setIn(tbl[1]);
    cycle("md32-abort2", 1'b0, 5'b00000, 1'b1, 5'b00000);

    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(63) == 0);
      rd      = 5'($urandom_range(3));
      rs1     = 5'($urandom_range(3));
      rs2     = 5'($urandom_range(3));
      use1    = 1'($urandom_range(1));
      use2    = 1'($urandom_range(1));
      memRead = 1'($urandom_range(1));
      mdStart = ($urandom_range(39) == 0);
      branch  = (aMd == 0 && bMd == 0 && !mdStart) ? ($urandom_range(7) == 0) : 1'b0;
      cycle("rand", 1'b0, 5'b00000, 1'b0, 5'b00000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Parametrised successor to the pipeline's combinational load-use detector, sitting in the ID stage of the 5-stage RV32IM pipeline. Adds:
- configurable multi-cycle load-use stalls for slower data memory;
- a multi-cycle MUL/DIV busy sequencer that freezes the front end and EX;
- taken-branch flush arbitration.
It drives all PC, IF/ID and ID/EX hold/flush controls from one place.

Parameters:
REG_ADDR_W, 5, register index width
LOAD_LAT, 1, cycles a load result is unavailable to a dependent ID instruction (1 = classic single bubble); legal 1..15
MD_LAT, 32, EX-stage occupancy in cycles of a multi-cycle MUL/DIV op; legal 2..64

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
if_id_rs1  in  REG_ADDR_W  rs1 of instruction in ID
if_id_rs2  in  REG_ADDR_W  rs2 of instruction in ID
if_id_use_rs1  in  1  ID instruction reads rs1
if_id_use_rs2  in  1  ID instruction reads rs2
id_ex_rd  in  REG_ADDR_W  rd of instruction in EX
id_ex_mem_read  in  1  EX instruction is a load
id_ex_md_start  in  1  EX instruction is a multi-cycle MUL/DIV, first EX cycle
branch_taken  in  1  branch/jump resolved taken in EX this cycle
pc_hold  out  1  hold PC and IF/ID
id_ex_bubble  out  1  load NOP into ID/EX next edge
ex_hold  out  1  hold ID/EX and EX operands; EX/MEM receives NOP
if_id_flush  out  1  load NOP into IF/ID next edge
md_busy  out  1  multi-cycle op in progress

Behaviour:
- Reset: synchronous, active-high, on clk rising edge. Clears load counter (lcnt) and MD counter (mcnt) to 0.
- With rst high, or all inputs low, every output is 0.
- rst asserted mid-stall or mid-MD aborts the operation; outputs are 0 the cycle after.
- Hazard match, combinational:
  - hit = id_ex_mem_read & id_ex_rd != 0 & ((if_id_use_rs1 & rs1 == rd) | (if_id_use_rs2 & rs2 == rd)).
  - Unused source fields never match.
- Load-use sequencing:
  - Cycle with hit and lcnt == 0: pc_hold=1, id_ex_bubble=1; lcnt loads LOAD_LAT-1.
  - While lcnt != 0: pc_hold=1, id_ex_bubble=1; lcnt decrements.
  - Total stall is exactly LOAD_LAT cycles per load. hit is not re-evaluated while lcnt != 0 (the load has left EX).
- MD state machine, states IDLE and BUSY:
  - IDLE -> BUSY on id_ex_md_start; mcnt loads MD_LAT-1.
  - BUSY: md_busy=1, ex_hold=1, pc_hold=1; mcnt decrements.
  - BUSY -> IDLE when mcnt reaches 1. On that final cycle ex_hold=0, so the result advances.
  - Total EX occupancy is MD_LAT cycles; the start cycle itself asserts ex_hold=1.
  - id_ex_md_start while BUSY is ignored (held instruction).
- Flush:
  - branch_taken: if_id_flush=1, id_ex_bubble=1, pc_hold=0.
  - branch_taken also clears lcnt to 0; the squashed instruction's stall is cancelled.
  - branch_taken while ex_hold=1 is illegal (branch cannot be in EX); the unit asserts nothing extra and the bench flags it.
- Priority:
  - rst > MD (ex_hold/pc_hold) > branch flush > load-use.
  - A load-use hit while BUSY does not start lcnt; it is re-evaluated after BUSY ends.
- Widths: lcnt is 4 bits; mcnt is $clog2(MD_LAT) bits. No wrap: counters decrement only when nonzero.
- All outputs are combinational from counters, state and current inputs. Zero added latency.

Decomposition:
- Shared pipeline package holds:
  - REG_ADDR_W default;
  - MD state enum (MD_IDLE, MD_BUSY);
  - NOP encoding constant used by the IF/ID and ID/EX flush muxes.
- One natural sub-module: hazard_stall_counter, a loadable down-counter with a nonzero flag. Instantiate it twice, for lcnt and mcnt.

Test Plan:
- LOAD_LAT=1; load x5 in EX, ID reads rs1=x5 -> pc_hold=1 and id_ex_bubble=1 for exactly 1 cycle, then 0.
- LOAD_LAT=3, same stimulus -> pc_hold=id_ex_bubble=1 for 3 consecutive cycles; rd=x0 or if_id_use_rs1=0 -> no stall.
- MD_LAT=4, id_ex_md_start pulse -> md_busy=1 for 4 cycles and ex_hold=1 for the first 3; pc_hold=1 for 4; back to IDLE.
- branch_taken with simultaneous load-use hit -> if_id_flush=1, id_ex_bubble=1, pc_hold=0; lcnt=0 next cycle.
- rst asserted in 2nd cycle of MD_LAT=32 op -> next cycle md_busy=0, ex_hold=0, pc_hold=0.
- Load-use hit during BUSY -> no lcnt load until IDLE; after IDLE, if hit persists, LOAD_LAT stall cycles follow.
